// File: rtl/fifo_stream_reader.sv
// Pop-side adapter: drains a registered-read FIFO into a valid/ready stream with packet framing.
// A 3-entry prefetch buffer absorbs the one-cycle read latency so sink stalls never drop data.
module fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            level
);

  localparam int unsigned CntW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PKT_LEN - 1);

  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [1:0]            head_q, head_d;
  logic [1:0]            tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  in_flight_q;
  logic [CntW-1:0]       word_cnt_q, word_cnt_d;
  logic                  push, pop;
  logic [2:0]            occupancy;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every outstanding pop so a returning word always has room.
  assign occupancy  = {1'b0, count_q} + {2'b00, in_flight_q};
  assign fifo_rd_en = rst_n & ~flush & ~fifo_empty & (occupancy < 3'd3);

  assign push    = in_flight_q;
  assign m_valid = (count_q != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_data  = m_valid ? mem_q[head_q] : '0;
  assign m_last  = m_valid & (word_cnt_q == LastCnt);
  assign level   = count_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    if (push) begin
      tail_d = ptr_inc(tail_q);
    end
    if (pop) begin
      head_d     = ptr_inc(head_q);
      word_cnt_d = (word_cnt_q == LastCnt) ? '0 : word_cnt_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      in_flight_q <= 1'b0;
      word_cnt_q  <= '0;
    end else if (flush) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      in_flight_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      in_flight_q <= fifo_rd_en;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Storage is qualified by in_flight, which reset clears, so it needs no reset itself.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[tail_q] <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural registered-read FIFO on the pop side,
// hand-computed expectations checked with immediate assertions.
module tb_fifo_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       flush;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [1:0] level;

  int n_checks = 0;
  int n_fail   = 0;
  int pops     = 0;
  int pops0;
  int got;

  logic [7:0] fmem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;

  fifo_stream_reader #(
    .DATA_WIDTH(8),
    .PKT_LEN   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .flush       (flush),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .level       (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // FIFO model with one-cycle registered read data.
  assign fifo_empty = (wr_ptr == rd_ptr);

  initial fifo_rd_data = 8'h00;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fmem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
      pops         <= pops + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    fmem[wr_ptr % 64] = v;
    wr_ptr++;
  endtask

  // Buffer occupancy plus outstanding pop must never exceed the three slots.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("occupancy_bound", 32'(int'(dut.count_q) + int'(dut.in_flight_q) <= 3), 32'd1);
    end
  end

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) load(8'(i));
    repeat (3) @(negedge clk);

    // Reset with a non-empty FIFO.
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pops", 32'(pops), 32'd0);

    // Release and stream 0x01..0x08 with the sink always ready.
    m_ready = 1'b1;
    rst_n   = 1'b1;
    #1;
    chk("rel_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    chk("rel_valid_c1", 32'(m_valid), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk("stream_valid", 32'(m_valid), 32'd1);
      chk("stream_data", 32'(m_data), 32'(k + 1));
      chk("stream_last", 32'(m_last), 32'((k == 3) || (k == 7)));
      @(negedge clk);
    end
    chk("stream_done_valid", 32'(m_valid), 32'd0);
    chk("stream_done_level", 32'(level), 32'd0);
    chk("stream_done_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("stream_pops", 32'(pops), 32'd8);

    // Backpressure: sink stalled with 8 words available.
    m_ready = 1'b0;
    pops0   = pops;
    for (int i = 1; i <= 8; i++) load(8'(i));
    repeat (6) @(negedge clk);
    chk("bp_pops", 32'(pops - pops0), 32'd3);
    chk("bp_level", 32'(level), 32'd3);
    chk("bp_data", 32'(m_data), 32'h01);
    chk("bp_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    chk("bp_data_hold", 32'(m_data), 32'h01);
    chk("bp_pops_hold", 32'(pops - pops0), 32'd3);
    m_ready = 1'b1;
    got     = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (m_valid) begin
        chk("bp_drain_data", 32'(m_data), 32'(got + 1));
        chk("bp_drain_last", 32'(m_last), 32'((got == 3) || (got == 7)));
        got++;
      end
      @(negedge clk);
    end
    chk("bp_drain_count", 32'(got), 32'd8);
    chk("bp_drain_level", 32'(level), 32'd0);
    chk("bp_drain_pops", 32'(pops - pops0), 32'd8);

    // Empty boundary and single-word refill.
    pops0 = pops;
    chk("empty_rd_en", 32'(fifo_rd_en), 32'd0);
    load(8'hA5);
    #1;
    chk("refill_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    chk("refill_rd_en_empty", 32'(fifo_rd_en), 32'd0);
    chk("refill_valid_c1", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("refill_valid", 32'(m_valid), 32'd1);
    chk("refill_data", 32'(m_data), 32'hA5);
    chk("refill_last", 32'(m_last), 32'd0);
    @(negedge clk);
    chk("refill_done_valid", 32'(m_valid), 32'd0);
    chk("refill_done_level", 32'(level), 32'd0);
    chk("refill_pops", 32'(pops - pops0), 32'd1);

    // Flush with two buffered words and one in flight; word counter was left at 1.
    m_ready = 1'b0;
    pops0   = pops;
    for (int i = 1; i <= 7; i++) load(8'(i * 8'h11));
    repeat (3) @(negedge clk);
    chk("pre_flush_level", 32'(level), 32'd2);
    chk("pre_flush_in_flight", 32'(dut.in_flight_q), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush_rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    chk("post_flush_level", 32'(level), 32'd0);
    chk("post_flush_valid", 32'(m_valid), 32'd0);
    m_ready = 1'b1;
    got     = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (m_valid) begin
        chk("flush_drain_data", 32'(m_data), 32'((got + 4) * 8'h11));
        chk("flush_drain_last", 32'(m_last), 32'(got == 3));
        got++;
      end
      @(negedge clk);
    end
    chk("flush_drain_count", 32'(got), 32'd4);
    chk("flush_pops", 32'(pops - pops0), 32'd7);

    // Asynchronous reset between clock edges.
    m_ready = 1'b0;
    load(8'h81);
    load(8'h82);
    repeat (4) @(negedge clk);
    chk("pre_areset_valid", 32'(m_valid), 32'd1);
    chk("pre_areset_level", 32'(level), 32'd2);
    chk("pre_areset_data", 32'(m_data), 32'h81);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 32'(m_valid), 32'd0);
    chk("areset_level", 32'(level), 32'd0);
    chk("areset_data", 32'(m_data), 32'd0);
    chk("areset_last", 32'(m_last), 32'd0);
    chk("areset_rd_en", 32'(fifo_rd_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Pop-side adapter that drains a `synchronous_fifo`-style read port and presents its contents as a valid/ready stream with packet framing. It issues pops against the FIFO's one-cycle registered read latency and holds returned words in a 3-entry prefetch buffer, so a stalled sink never loses data. There is no combinational path from the sink's `m_ready` to `fifo_rd_en`. The block sits between a FIFO and any downstream stream consumer.

## Interface
- `DATA_WIDTH`, default 8: word width.
- `PKT_LEN`, default 4: words per packet; must be ≥ 1. `m_last` marks the final word of each packet.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: pop request to the FIFO.
- `fifo_rd_data`  in  DATA_WIDTH: FIFO read data. Valid the cycle after a cycle with `fifo_rd_en`=1.
- `flush`  in  1: synchronous discard of buffered and in-flight words; also resets the packet counter.
- `m_valid`  out  1: output word valid (registered).
- `m_ready`  in  1: sink accepts the word.
- `m_data`  out  DATA_WIDTH: output word (registered).
- `m_last`  out  1: last word of a packet. Meaningful only while `m_valid`=1.
- `level`  out  2: buffered word count, 0..3.

## Operation
- **State**
  - 3-entry in-order buffer with head, tail and count (0..3).
  - `in_flight` flag: a pop was issued last cycle and its data arrives this cycle.
  - `word_cnt`: counter of width clog2(PKT_LEN), minimum 1 bit.
- **Pop issue**
  - `fifo_rd_en = rst_n & !flush & !fifo_empty & (count + in_flight < 3)`.
  - Depends only on registered state, `fifo_empty` and `flush`.
- **`in_flight`**
  - Next value is `fifo_rd_en`.
  - When set, `fifo_rd_data` is written at the tail on the following edge.
- **Output**
  - `m_valid` = (count ≠ 0).
  - `m_data` = the head entry.
  - A transfer occurs on a rising edge with `m_valid & m_ready`. The head then advances.
  - A push and a transfer in the same cycle leave count unchanged.
  - Words are delivered in pop order, with no duplication or loss.
- **Framing**
  - `word_cnt` increments on each transfer and wraps from PKT_LEN-1 to 0.
  - `m_last` = `m_valid & (word_cnt == PKT_LEN-1)`.
  - With PKT_LEN=1, `m_last` = `m_valid`.
- **Flush**
  - On an edge with `flush`=1: count, head, tail, `word_cnt` and `in_flight` go to 0.
  - A word arriving that cycle is dropped.
  - A transfer completing on the same edge counts as delivered. Everything else is discarded.
  - `fifo_rd_en` is 0 during the flush cycle.
- **Overflow**
  - count + `in_flight` never exceeds 3 by construction.
  - Verification asserts this, and asserts that no arrival occurs when count=3 without a simultaneous transfer.
- **`level`** = count.

## Timing
- **Reset (`rst_n`=0, asynchronous)**
  - `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `level`=0.
  - `in_flight`=0, `word_cnt`=0.
  - Buffer RAM contents need not reset.
- **Reset mid-operation:** all buffered and in-flight words are lost. The FIFO's own reset is the system's responsibility.
- **Latency:** `fifo_rd_en` high in cycle N → data captured at the end of cycle N+1 → `m_valid` high in cycle N+2.
- **Throughput:** 1 word/cycle sustained when the FIFO is non-empty and `m_ready` is held at 1. Steady state is count=1, `in_flight`=1.
- **Backpressure:** with `m_ready`=0, at most 3 pops are issued. `fifo_rd_en` drops once count + `in_flight` = 3.
  - After `m_ready` rises, a new pop is issued one cycle after the first transfer.
- **Empty boundary:** `fifo_rd_en` follows `fifo_empty` combinationally. No pop is issued when `fifo_empty`=1.
- **Same-cycle events:**
  - Arrival and transfer in one cycle: the level holds.
  - Arrival into an empty buffer: `m_valid` rises on the next edge. There is no bypass.

## Test plan
- **Reset:** hold `rst_n`=0 with the FIFO non-empty → `fifo_rd_en`=0 and all outputs 0. Release → `fifo_rd_en`=1 in the first cycle, `m_valid`=1 two cycles later.
- **Streaming:** FIFO loaded with 0x01..0x08, PKT_LEN=4, `m_ready`=1 → eight consecutive transfers 0x01..0x08 with no bubbles. `m_last`=1 on 0x04 and 0x08 only.
- **Backpressure:** `m_ready`=0 with 8 words in the FIFO → exactly 3 pops, `level`=3, `m_data`=0x01 held stable. Release `m_ready` → 0x01..0x08 delivered in order, no loss.
- **Empty/refill:** a single word 0xA5 written to an empty FIFO → exactly one pop, one transfer of 0xA5, `level` returns to 0, and `fifo_rd_en` stays 0 while `fifo_empty`=1.
- **Flush:** `level`=2 with a word in flight, `m_ready`=0, assert `flush` one cycle → `level`=0, `m_valid`=0 next cycle. The in-flight word is dropped. The next delivered word has `word_cnt`=0, and `m_last` first appears on the 4th word after the flush.
- **Async reset mid-burst:** drop `rst_n` between clock edges → outputs clear immediately, with no clock edge required.
